data_memory_unit: RTL

Word-addressed data memory stage that sits directly downstream of the ALU in the LEGv8-style processor. It consumes the ALU result as a byte address and the second register-file read value as store data, and it serves LDUR and STUR. Each access takes a parameterised number of wait states. While an access is pending the unit stalls the processor through a busy/done handshake, and it flags misaligned or out-of-range accesses.

---
 rtl/dmem_pkg.sv | 34 +++
 rtl/dmem_array.sv | 25 ++
 rtl/data_memory_unit.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/dmem_pkg.sv
// Shared types and constants for the data memory stage.
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } dmem_state_t;

  localparam int DMEM_WAIT_W = 4;

  // Fault causes, one bit each so several can be reported together.
  localparam logic [2:0] DMEM_FAULT_NONE  = 3'b000;
  localparam logic [2:0] DMEM_FAULT_ALIGN = 3'b001;
  localparam logic [2:0] DMEM_FAULT_RANGE = 3'b010;
  localparam logic [2:0] DMEM_FAULT_DUAL  = 3'b100;

  // Classify a request: low address bits set, any address bit above the
  // word index set, or load and store requested at once.
  function automatic logic [2:0] dmem_fault(input logic [31:0] addr,
                                            input logic        rd,
                                            input logic        wr,
                                            input int unsigned addr_w);
    logic [31:0] hi;
    logic [2:0]  cause;
    hi    = addr >> (addr_w + 2);
    cause = DMEM_FAULT_NONE;
    if (addr[1:0] != 2'b00) cause = cause | DMEM_FAULT_ALIGN;
    if (hi != 32'd0)        cause = cause | DMEM_FAULT_RANGE;
    if (rd && wr)           cause = cause | DMEM_FAULT_DUAL;
    return cause;
  endfunction

endpackage

// File: rtl/dmem_array.sv
// Single-port word RAM with write enable and an enable-gated registered read.
// No reset on the storage or the read register.
module dmem_array #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic              re_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [31:0]       wdata_i,
  output logic [31:0]       rdata_o
);

  logic [31:0] mem_q [0:(1<<ADDR_W)-1];
  logic [31:0] rdata_q;

  // Write and read share one port; the read register holds between reads.
  always_ff @(posedge clk) begin
    if (we_i) mem_q[addr_i] <= wdata_i;
    if (re_i) rdata_q <= mem_q[addr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/data_memory_unit.sv
// LDUR/STUR data memory stage with programmable wait states and a
// busy/done handshake toward the pipeline.
//
// state | meaning
// IDLE  | waiting for a request
// WAIT  | counting wait states (down-counter, exits at 0)
// DONE  | one-cycle completion, inputs ignored
module data_memory_unit
  import dmem_pkg::*;
#(
  parameter int ADDR_W      = 8,
  parameter int WAIT_STATES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] ALU_Result,
  input  logic [31:0] Write_data,
  input  logic        MemRead,
  input  logic        MemWrite,
  output logic [31:0] Read_data,
  output logic        Mem_busy,
  output logic        Mem_done,
  output logic        Mem_error
);

  localparam logic [DMEM_WAIT_W-1:0] WAIT_LOAD =
    (WAIT_STATES > 0) ? DMEM_WAIT_W'(WAIT_STATES - 1) : '0;

  dmem_state_t            state_q, state_d;
  logic [DMEM_WAIT_W-1:0] cnt_q, cnt_d;
  logic [ADDR_W-1:0]      idx_q, idx_d;
  logic [31:0]            wdata_q, wdata_d;
  logic                   rd_q, rd_d;
  logic                   wr_q, wr_d;
  logic                   err_q, err_d;
  logic                   loaded_q, loaded_d;

  logic                   req;
  logic [2:0]             fault;
  logic [ADDR_W-1:0]      in_idx;
  logic                   mem_we, mem_re;
  logic [ADDR_W-1:0]      mem_idx;
  logic [31:0]            mem_wdata;
  logic [31:0]            arr_rdata;

  assign req    = MemRead | MemWrite;
  assign in_idx = ALU_Result[ADDR_W+1:2];
  assign fault  = dmem_fault(ALU_Result, MemRead, MemWrite, ADDR_W);

  dmem_array #(.ADDR_W(ADDR_W)) u_array (
    .clk     (clk),
    .we_i    (mem_we),
    .re_i    (mem_re),
    .addr_i  (mem_idx),
    .wdata_i (mem_wdata),
    .rdata_o (arr_rdata)
  );

  // State, wait counter and latched request; reset drops any pending access.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      idx_q    <= '0;
      wdata_q  <= '0;
      rd_q     <= 1'b0;
      wr_q     <= 1'b0;
      err_q    <= 1'b0;
      loaded_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      wdata_q  <= wdata_d;
      rd_q     <= rd_d;
      wr_q     <= wr_d;
      err_q    <= err_d;
      loaded_q <= loaded_d;
    end
  end

  // Next-state: accept in IDLE only, faults skip straight to DONE.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    wdata_d = wdata_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (req) begin
          idx_d   = in_idx;
          wdata_d = Write_data;
          rd_d    = MemRead;
          wr_d    = MemWrite;
          err_d   = (fault != DMEM_FAULT_NONE);
          if (fault != DMEM_FAULT_NONE || WAIT_STATES == 0) begin
            state_d = DONE;
          end else begin
            state_d = WAIT;
            cnt_d   = WAIT_LOAD;
          end
        end
      end
      WAIT: begin
        if (cnt_q == '0) begin
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - DMEM_WAIT_W'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
        err_d   = 1'b0;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
    loaded_d = loaded_q | mem_re;
  end

  // Outputs and the commit strobe into the array on the edge entering DONE.
  always_comb begin
    mem_we    = 1'b0;
    mem_re    = 1'b0;
    mem_idx   = idx_q;
    mem_wdata = wdata_q;
    if (state_q == IDLE && req && fault == DMEM_FAULT_NONE && WAIT_STATES == 0) begin
      mem_we    = MemWrite;
      mem_re    = MemRead;
      mem_idx   = in_idx;
      mem_wdata = Write_data;
    end else if (state_q == WAIT && cnt_q == '0) begin
      mem_we = wr_q;
      mem_re = rd_q;
    end
    Mem_busy  = rst_n & ((state_q == IDLE && req) || state_q == WAIT);
    Mem_done  = (state_q == DONE);
    Mem_error = err_q & (state_q == DONE);
    Read_data = loaded_q ? arr_rdata : 32'd0;
  end

endmodule
